// File: rtl/ex_div.sv
// rtl/ex_div.sv - multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
module ex_div #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic                      flush_i,
  input  logic                      hold_i,
  input  logic [1:0]                op_i,
  input  logic [DATA_WIDTH-1:0]     dividend_i,
  input  logic [DATA_WIDTH-1:0]     divisor_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0]     result_o,
  output logic                      ready_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
  output logic                      wait_req_o,
  output logic                      busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                      state_q, state_d;
  logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]       quo_q, quo_d;
  logic [DATA_WIDTH-1:0]       rem_q, rem_d;
  logic [DATA_WIDTH-1:0]       dvsr_q, dvsr_d;
  logic [DATA_WIDTH-1:0]       result_q, result_d;
  logic [REG_ADDR_WIDTH-1:0]   rd_q, rd_d;
  logic                        op_rem_q, op_rem_d;
  logic                        q_neg_q, q_neg_d;
  logic                        r_neg_q, r_neg_d;
  logic                        ready_q, ready_d;
  logic                        busy_q, busy_d;

  // Operand preparation for the accept cycle: magnitudes, signs and the
  // two cases that bypass the iteration loop.
  logic                  is_signed;
  logic                  a_neg;
  logic                  b_neg;
  logic [DATA_WIDTH-1:0] a_abs;
  logic [DATA_WIDTH-1:0] b_abs;
  logic                  div_zero;
  logic                  sgn_ovf;

  assign is_signed = ~op_i[0];
  assign a_neg     = is_signed & dividend_i[DATA_WIDTH-1];
  assign b_neg     = is_signed & divisor_i[DATA_WIDTH-1];
  assign a_abs     = a_neg ? (~dividend_i + 1'b1) : dividend_i;
  assign b_abs     = b_neg ? (~divisor_i + 1'b1) : divisor_i;
  assign div_zero  = (divisor_i == '0);
  assign sgn_ovf   = is_signed
                   & (dividend_i == {1'b1, {(DATA_WIDTH-1){1'b0}}})
                   & (divisor_i == '1);

  // One restoring step. The shifted partial remainder can reach twice the
  // divisor, so the compare/subtract is one bit wider than the data; the
  // top bit of the difference is the borrow.
  logic [DATA_WIDTH:0]   rem_sh;
  logic [DATA_WIDTH:0]   diff;
  logic                  fits;
  logic [DATA_WIDTH-1:0] step_rem;
  logic [DATA_WIDTH-1:0] step_quo;
  logic [DATA_WIDTH-1:0] quo_fix;
  logic [DATA_WIDTH-1:0] rem_fix;
  logic                  last_iter;

  assign rem_sh    = {rem_q, quo_q[DATA_WIDTH-1]};
  assign diff      = rem_sh - {1'b0, dvsr_q};
  assign fits      = ~diff[DATA_WIDTH];
  assign step_rem  = fits ? diff[DATA_WIDTH-1:0] : rem_sh[DATA_WIDTH-1:0];
  assign step_quo  = {quo_q[DATA_WIDTH-2:0], fits};
  assign quo_fix   = q_neg_q ? (~step_quo + 1'b1) : step_quo;
  assign rem_fix   = r_neg_q ? (~step_rem + 1'b1) : step_rem;
  assign last_iter = (cnt_q == CNT_WIDTH'(DATA_WIDTH - 1));

  // Stall the pipeline from the accept cycle through the last iteration;
  // dropping it in DONE lets the pipeline advance on the ready cycle.
  assign wait_req_o = ((state_q == IDLE) & start_i & ~flush_i) | (state_q == CALC);

  // Next-state and datapath update; flush wins over everything else.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvsr_d   = dvsr_q;
    result_d = result_q;
    rd_d     = rd_q;
    op_rem_d = op_rem_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;

    if (flush_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            op_rem_d = op_i[1];
            rd_d     = rd_addr_i;
            q_neg_d  = a_neg ^ b_neg;
            r_neg_d  = a_neg;
            quo_d    = a_abs;
            rem_d    = '0;
            dvsr_d   = b_abs;
            cnt_d    = '0;
            if (div_zero) begin
              result_d = op_i[1] ? dividend_i : '1;
              state_d  = DONE;
            end else if (sgn_ovf) begin
              result_d = op_i[1] ? '0 : dividend_i;
              state_d  = DONE;
            end else begin
              state_d  = CALC;
            end
          end
        end
        CALC: begin
          quo_d = step_quo;
          rem_d = step_rem;
          cnt_d = cnt_q + 1'b1;
          if (last_iter) begin
            result_d = op_rem_q ? rem_fix : quo_fix;
            state_d  = DONE;
          end
        end
        DONE: begin
          if (!hold_i) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign ready_d = (state_d == DONE);
  assign busy_d  = (state_d != IDLE);

  // State register with synchronous reset; status outputs are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvsr_q   <= '0;
      result_q <= '0;
      rd_q     <= '0;
      op_rem_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvsr_q   <= dvsr_d;
      result_q <= result_d;
      rd_q     <= rd_d;
      op_rem_q <= op_rem_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign result_o  = result_q;
  assign ready_o   = ready_q;
  assign rd_addr_o = rd_q;
  assign busy_o    = busy_q;

endmodule
